// File: rtl/mem_arb_pkg.sv
// Shared definitions for the data-RAM arbiter.
//   - default widths and starvation limit
//   - arbiter FSM state encoding
package mem_arb_pkg;

    localparam int ADDR_W_DEF       = 14;
    localparam int DATA_W_DEF       = 32;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [2:0] {
        BOOT    = 3'd0,
        IDLE    = 3'd1,
        CPU_CMD = 3'd2,
        CPU_ACK = 3'd3,
        UPG_CMD = 3'd4
    } arb_state_t;

endpackage

// File: rtl/mem_arb_stats.sv
// Saturating 16-bit event counter for arbitration conflicts.
// Ports:
//   clk, rst  - clock, synchronous active-low reset
//   inc_i     - count this cycle
//   cnt_o     - current count, sticks at 16'hFFFF
module mem_arb_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    output logic [15:0] cnt_o
);

    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= 16'h0000;
        end else if (inc_i && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'h0001;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Data-RAM arbiter between the CPU load/store port and the UART programmer.
// Build option: define MEM_ARB_STATS_EN to include the conflict counter.
// Ports:
//   clk, rst                      - clock, synchronous active-low reset
//   cpu_req/we/adr/dat_i          - CPU access request
//   cpu_dat_o, cpu_ack_o, stall_o - CPU load data, completion, pipeline hold
//   upg_wen/adr/dat/done_i        - programmer write stream (adr MSB = data RAM)
//   upg_rdy_o                     - programmer write accepted this cycle
//   ram_en/we/adr/dat_o, ram_dat_i- synchronous RAM port (1-cycle read latency)
//   conflict_cnt_o                - cycles in IDLE with both requesters pending
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_adr_i,
    input  logic [DATA_W-1:0] cpu_dat_i,
    output logic [DATA_W-1:0] cpu_dat_o,
    output logic              cpu_ack_o,
    output logic              stall_o,
    input  logic              upg_wen_i,
    input  logic [ADDR_W:0]   upg_adr_i,
    input  logic [DATA_W-1:0] upg_dat_i,
    input  logic              upg_done_i,
    output logic              upg_rdy_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_adr_o,
    output logic [DATA_W-1:0] ram_dat_o,
    input  logic [DATA_W-1:0] ram_dat_i,
    output logic [15:0]       conflict_cnt_o
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_t        state_q, state_d;
    logic              ret_boot_q, ret_boot_d;   // UPG_CMD returns to BOOT when set
    logic [SW-1:0]     starve_q, starve_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_adr_q, ram_adr_d;
    logic [DATA_W-1:0] ram_dat_q, ram_dat_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              cpu_we_q, cpu_we_d;
    logic [DATA_W-1:0] cpu_dat_q, cpu_dat_d;

    logic cpu_forced;
    logic upg_acc;

    // When the CPU has lost STARVE_LIMIT times the programmer is refused
    // outright, so its write is never silently dropped by a CPU win.
    assign cpu_forced = upg_done_i && cpu_req_i && (starve_q == STARVE_MAX);
    assign upg_rdy_o  = (state_q == BOOT) || ((state_q == IDLE) && !cpu_forced);
    assign upg_acc    = upg_wen_i && upg_rdy_o;

    always_comb begin
        state_d    = state_q;
        ret_boot_d = ret_boot_q;
        starve_d   = starve_q;
        ram_en_d   = 1'b0;
        ram_we_d   = 1'b0;
        ram_adr_d  = ram_adr_q;
        ram_dat_d  = ram_dat_q;
        cpu_ack_d  = 1'b0;
        cpu_we_d   = cpu_we_q;
        cpu_dat_d  = cpu_dat_q;

        case (state_q)
            BOOT: begin
                if (upg_acc && upg_adr_i[ADDR_W]) begin
                    state_d    = UPG_CMD;
                    ret_boot_d = 1'b1;
                    ram_en_d   = 1'b1;
                    ram_we_d   = 1'b1;
                    ram_adr_d  = upg_adr_i[ADDR_W-1:0];
                    ram_dat_d  = upg_dat_i;
                end else if (upg_done_i) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (upg_acc) begin
                    // Programmer wins; a waiting CPU records the loss.
                    if (cpu_req_i && upg_done_i && (starve_q != STARVE_MAX)) begin
                        starve_d = starve_q + 1'b1;
                    end
                    if (upg_adr_i[ADDR_W]) begin
                        state_d    = UPG_CMD;
                        ret_boot_d = !upg_done_i;
                        ram_en_d   = 1'b1;
                        ram_we_d   = 1'b1;
                        ram_adr_d  = upg_adr_i[ADDR_W-1:0];
                        ram_dat_d  = upg_dat_i;
                    end else if (!upg_done_i) begin
                        state_d = BOOT;
                    end
                end else if (!upg_done_i) begin
                    state_d = BOOT;
                end else if (cpu_req_i) begin
                    state_d   = CPU_CMD;
                    starve_d  = '0;
                    ram_en_d  = 1'b1;
                    ram_we_d  = cpu_we_i;
                    ram_adr_d = cpu_adr_i;
                    ram_dat_d = cpu_dat_i;
                    cpu_we_d  = cpu_we_i;
                end
            end
            CPU_CMD: begin
                state_d   = CPU_ACK;
                cpu_ack_d = 1'b1;
            end
            CPU_ACK: begin
                // Request is ignored here; the next grant comes from IDLE.
                state_d = IDLE;
                if (!cpu_we_q) begin
                    cpu_dat_d = ram_dat_i;
                end
            end
            UPG_CMD: begin
                state_d = ret_boot_q ? BOOT : IDLE;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= BOOT;
            ret_boot_q <= 1'b1;
            starve_q   <= '0;
            ram_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_adr_q  <= '0;
            ram_dat_q  <= '0;
            cpu_ack_q  <= 1'b0;
            cpu_we_q   <= 1'b0;
            cpu_dat_q  <= '0;
        end else begin
            state_q    <= state_d;
            ret_boot_q <= ret_boot_d;
            starve_q   <= starve_d;
            ram_en_q   <= ram_en_d;
            ram_we_q   <= ram_we_d;
            ram_adr_q  <= ram_adr_d;
            ram_dat_q  <= ram_dat_d;
            cpu_ack_q  <= cpu_ack_d;
            cpu_we_q   <= cpu_we_d;
            cpu_dat_q  <= cpu_dat_d;
        end
    end

    assign ram_en_o  = ram_en_q;
    assign ram_we_o  = ram_we_q;
    assign ram_adr_o = ram_adr_q;
    assign ram_dat_o = ram_dat_q;
    assign cpu_ack_o = cpu_ack_q;
    assign stall_o   = cpu_req_i && !cpu_ack_q;

    // RAM read data arrives in the ack cycle; pass it straight through then
    // and hold the captured copy until the next load completes.
    assign cpu_dat_o = ((state_q == CPU_ACK) && !cpu_we_q) ? ram_dat_i : cpu_dat_q;

`ifdef MEM_ARB_STATS_EN
    logic both_pending;
    assign both_pending = (state_q == IDLE) && cpu_req_i && upg_wen_i;

    mem_arb_stats u_stats (
        .clk   (clk),
        .rst   (rst),
        .inc_i (both_pending),
        .cnt_o (conflict_cnt_o)
    );
`else
    assign conflict_cnt_o = 16'h0000;
`endif

endmodule
